// File: rtl/mel_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mel_frame_ctrl_if
// Description : Control and sample bus between a host and mel_frame_ctrl.
//               Upstream samples, STFT drive, mel-side strobes and status.
//               The slave modport is the controller's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mel_frame_ctrl_if #(
  parameter int WIDTH     = 16,
  parameter int N_FRAMES  = 101,
  parameter int MEL_BANDS = 40
);
  localparam int c_BAND_W = (MEL_BANDS > 1) ? $clog2(MEL_BANDS) : 1;
  localparam int c_FIDX_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;

  logic                i_start;
  logic                i_abort;
  logic                i_s_valid;
  logic                o_s_ready;
  logic [WIDTH-1:0]    i_s_re;
  logic [WIDTH-1:0]    i_s_im;
  logic                o_sig_en;
  logic [WIDTH-1:0]    o_sig_re;
  logic [WIDTH-1:0]    o_sig_im;
  logic                i_buf_full;
  logic                i_mel_avail;
  logic [c_BAND_W-1:0] o_band_idx;
  logic [c_FIDX_W-1:0] o_frame_idx;
  logic                o_frame_done;
  logic                o_busy;
  logic                o_done;
  logic                o_err;

  modport slave (
    input  i_start, i_abort, i_s_valid, i_s_re, i_s_im, i_buf_full, i_mel_avail,
    output o_s_ready, o_sig_en, o_sig_re, o_sig_im, o_band_idx, o_frame_idx,
           o_frame_done, o_busy, o_done, o_err
  );

  modport master (
    output i_start, i_abort, i_s_valid, i_s_re, i_s_im, i_buf_full, i_mel_avail,
    input  o_s_ready, o_sig_en, o_sig_re, o_sig_im, o_band_idx, o_frame_idx,
           o_frame_done, o_busy, o_done, o_err
  );
endinterface
`default_nettype wire

// File: rtl/mel_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mel_frame_ctrl
// Description : Frame sequencer in front of the Mel-spectrogram top. Gates
//               WIN_LEN samples for frame 0 and HOP_LEN per later frame,
//               throttles on buf_full and on the input/output frame lead,
//               and turns mel_avail strobes into band/frame indices.
//               Optional DRAIN watchdog: define MEL_CTRL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mel_frame_ctrl #(
  parameter int WIDTH      = 16,
  parameter int N_FRAMES   = 101,
  parameter int WIN_LEN    = 480,
  parameter int HOP_LEN    = 160,
  parameter int MEL_BANDS  = 40,
  parameter int FRAME_LEAD = 2
`ifdef MEL_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  wire              clk,
  input  wire              rst,
  mel_frame_ctrl_if.slave  bus
);

  localparam int c_IN_MAX    = (WIN_LEN > HOP_LEN) ? WIN_LEN : HOP_LEN;
  localparam int c_INCNT_W   = $clog2(c_IN_MAX + 1);
  localparam int c_FRM_W     = $clog2(N_FRAMES + 1);
  localparam int c_BANDCNT_W = $clog2(MEL_BANDS + 1);
  localparam int c_BAND_W    = (MEL_BANDS > 1) ? $clog2(MEL_BANDS) : 1;
  localparam int c_FIDX_W    = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_HOP   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]             r_state;
  logic [2:0]             w_state_nxt;
  logic [c_INCNT_W-1:0]   r_in_cnt;
  logic [c_FRM_W-1:0]     r_in_frm;
  logic [c_FRM_W-1:0]     r_out_frm;
  logic [c_BANDCNT_W-1:0] r_band_cnt;
  logic                   r_sig_en;
  logic [WIDTH-1:0]       r_sig_re;
  logic [WIDTH-1:0]       r_sig_im;

  logic               w_active;
  logic               w_lead_stall;
  logic               w_s_ready;
  logic               w_hs;
  logic               w_in_last;
  logic [c_FRM_W-1:0] w_in_frm_nxt;
  logic               w_mel;
  logic               w_band_last;
  logic               w_out_last;
  logic               w_timeout;

  // Input/output progress conditions derived from the counters
  always_comb begin
    w_active     = (r_state == S_FILL) || (r_state == S_HOP) || (r_state == S_DRAIN);
    // Signed compare so a spurious early output frame never wraps into a stall
    w_lead_stall = (int'(r_in_frm) >= int'(r_out_frm) + FRAME_LEAD);
    w_s_ready    = ((r_state == S_FILL) || (r_state == S_HOP)) &&
                   !bus.i_buf_full && !w_lead_stall && !bus.i_abort;
    w_hs         = bus.i_s_valid && w_s_ready;
    w_in_last    = w_hs &&
                   (((r_state == S_FILL) && (r_in_cnt == c_INCNT_W'(WIN_LEN - 1))) ||
                    ((r_state == S_HOP)  && (r_in_cnt == c_INCNT_W'(HOP_LEN - 1))));
    w_in_frm_nxt = r_in_frm + c_FRM_W'(1);
    w_mel        = bus.i_mel_avail && w_active;
    w_band_last  = w_mel && (r_band_cnt == c_BANDCNT_W'(MEL_BANDS - 1));
    w_out_last   = w_band_last && (r_out_frm == c_FRM_W'(N_FRAMES - 1));
  end

`ifdef MEL_CTRL_TIMEOUT_EN
  localparam int c_WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [c_WD_W-1:0] r_wd;
  logic              r_err;

  // Watchdog fires on the TIMEOUT_CYC-th quiet DRAIN cycle
  always_comb begin
    w_timeout = (r_state == S_DRAIN) && !bus.i_mel_avail &&
                (r_wd == c_WD_W'(TIMEOUT_CYC - 1));
  end

  // Count consecutive DRAIN cycles without a mel strobe
  always_ff @(posedge clk) begin
    if (rst || bus.i_abort || (r_state != S_DRAIN) || bus.i_mel_avail || w_timeout) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + c_WD_W'(1);
    end
  end

  // Sticky error, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end
`else
  logic r_err;

  // No watchdog: DRAIN waits indefinitely and err stays low
  always_comb begin
    w_timeout = 1'b0;
    r_err     = 1'b0;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; abort overrides everything including start
  always_comb begin
    w_state_nxt = r_state;
    if (bus.i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            w_state_nxt = S_FILL;
          end
        end
        S_FILL: begin
          if (w_out_last) begin
            w_state_nxt = S_DONE;
          end else if (w_in_last) begin
            w_state_nxt = (N_FRAMES == 1) ? S_DRAIN : S_HOP;
          end
        end
        S_HOP: begin
          if (w_out_last) begin
            w_state_nxt = S_DONE;
          end else if (w_in_last && (w_in_frm_nxt == c_FRM_W'(N_FRAMES))) begin
            w_state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_out_last) begin
            w_state_nxt = S_DONE;
          end else if (w_timeout) begin
            w_state_nxt = S_IDLE;
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Status and handshake outputs decoded from state and counters
  always_comb begin
    bus.o_s_ready    = w_s_ready;
    bus.o_busy       = (r_state != S_IDLE);
    bus.o_done       = (r_state == S_DONE);
    bus.o_frame_done = w_band_last;
    bus.o_band_idx   = r_band_cnt[c_BAND_W-1:0];
    bus.o_frame_idx  = r_out_frm[c_FIDX_W-1:0];
    bus.o_sig_en     = r_sig_en;
    bus.o_sig_re     = r_sig_re;
    bus.o_sig_im     = r_sig_im;
    bus.o_err        = r_err;
  end

  // Input and output frame counters; both sides may advance in the same cycle
  always_ff @(posedge clk) begin
    if (rst || bus.i_abort || w_timeout || !w_active) begin
      r_in_cnt   <= '0;
      r_in_frm   <= '0;
      r_out_frm  <= '0;
      r_band_cnt <= '0;
    end else begin
      if (w_in_last) begin
        r_in_cnt <= '0;
        r_in_frm <= w_in_frm_nxt;
      end else if (w_hs) begin
        r_in_cnt <= r_in_cnt + c_INCNT_W'(1);
      end
      if (w_band_last) begin
        r_band_cnt <= '0;
        r_out_frm  <= r_out_frm + c_FRM_W'(1);
      end else if (w_mel) begin
        r_band_cnt <= r_band_cnt + c_BANDCNT_W'(1);
      end
    end
  end

  // One-cycle sample pipeline into the STFT; data holds when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig_en <= 1'b0;
      r_sig_re <= '0;
      r_sig_im <= '0;
    end else begin
      r_sig_en <= w_hs;
      if (w_hs) begin
        r_sig_re <= bus.i_s_re;
        r_sig_im <= bus.i_s_im;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mel_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mel_frame_ctrl
// Description : Self-checking bench for mel_frame_ctrl: vector table, directed
//               corner sequences and random traffic against a reference model
//               built on total-sample and total-strobe arithmetic.
//               Watchdog sequence active when MEL_CTRL_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mel_frame_ctrl;
  localparam int W     = 16;
  localparam int NF    = 3;
  localparam int WL    = 8;
  localparam int HL    = 4;
  localparam int MB    = 2;
  localparam int FL    = 2;
  localparam int TO    = 16;
  localparam int TOTAL = WL + (NF - 1) * HL;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mel_frame_ctrl_if #(.WIDTH(W), .N_FRAMES(NF), .MEL_BANDS(MB)) bus ();

  mel_frame_ctrl #(
    .WIDTH(W), .N_FRAMES(NF), .WIN_LEN(WL), .HOP_LEN(HL),
    .MEL_BANDS(MB), .FRAME_LEAD(FL)
`ifdef MEL_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYC(TO)
`endif
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit st, ab, sv, bf, ma;
    bit e_ready, e_busy, e_sig;
  } vec_t;

  int n_cmp, n_bad;
  // reference model state: run flags plus totals of accepted samples and strobes
  bit m_run, m_donep, m_err, m_hs, prev_hs;
  int m_total, m_mel, m_idle;
  logic [W-1:0] m_re, m_im;
  int dut_hs, dut_sig, dut_done, mcount;
  bit fin, ma;
  vec_t tv[11];

  function automatic int in_frames(int total);
    if (total < WL) return 0;
    return 1 + (total - WL) / HL;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit st, bit ab, bit sv, bit bf, bit mav);
    bus.i_start     = st;
    bus.i_abort     = ab;
    bus.i_s_valid   = sv;
    bus.i_buf_full  = bf;
    bus.i_mel_avail = mav;
    bus.i_s_re      = W'($urandom);
    bus.i_s_im      = W'($urandom);
  endtask

  // mid-cycle comparison of every output against the model
  task automatic eval();
    int  inf, outf;
    bit  e_rdy;
    #1;
    outf  = m_mel / MB;
    inf   = in_frames(m_total);
    e_rdy = m_run && (m_total < TOTAL) && !bus.i_buf_full && ((inf - outf) < FL) && !bus.i_abort;
    check("ready", 32'(bus.o_s_ready), 32'(e_rdy));
    check("busy", 32'(bus.o_busy), 32'(m_run || m_donep));
    check("done", 32'(bus.o_done), 32'(m_donep));
    check("sig_en", 32'(bus.o_sig_en), 32'(prev_hs));
    check("sig_re", 32'(bus.o_sig_re), 32'(m_re));
    check("sig_im", 32'(bus.o_sig_im), 32'(m_im));
    check("band_idx", 32'(bus.o_band_idx), m_run ? 32'(m_mel % MB) : 32'd0);
    check("frame_done", 32'(bus.o_frame_done),
          32'(m_run && bus.i_mel_avail && ((m_mel % MB) == MB - 1)));
    if (!m_donep) check("frame_idx", 32'(bus.o_frame_idx), m_run ? 32'(outf) : 32'd0);
    check("err", 32'(bus.o_err), 32'(m_err));
    if (bus.i_s_valid && bus.o_s_ready) dut_hs++;
    if (bus.o_sig_en) dut_sig++;
    if (bus.o_done) dut_done++;
    m_hs = bus.i_s_valid && e_rdy;
  endtask

  task automatic tick();
    bit drain;
    @(posedge clk);
    if (m_hs) begin
      m_re = bus.i_s_re;
      m_im = bus.i_s_im;
    end
    prev_hs = m_hs;
    if (bus.i_abort) begin
      m_run = 0; m_donep = 0; m_total = 0; m_mel = 0; m_idle = 0;
    end else if (m_donep) begin
      m_donep = 0;
    end else if (!m_run) begin
      if (bus.i_start) begin
        m_run = 1; m_total = 0; m_mel = 0; m_idle = 0;
      end
    end else begin
      drain = (m_total == TOTAL);
      if (m_hs) m_total++;
      if (bus.i_mel_avail) m_mel++;
      if (m_mel == NF * MB) begin
        m_run = 0; m_donep = 1;
      end
`ifdef MEL_CTRL_TIMEOUT_EN
      else if (drain && !bus.i_mel_avail) begin
        m_idle++;
        if (m_idle == TO) begin
          m_err = 1; m_run = 0; m_total = 0; m_mel = 0; m_idle = 0;
        end
      end else begin
        m_idle = 0;
      end
`else
      if (drain) m_idle = 0;
`endif
    end
    #1;
  endtask

  task automatic cyc(bit st, bit ab, bit sv, bit bf, bit mav);
    drive(st, ab, sv, bf, mav);
    eval();
    tick();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    m_run = 0; m_donep = 0; m_err = 0; m_hs = 0; prev_hs = 0;
    m_total = 0; m_mel = 0; m_idle = 0; m_re = '0; m_im = '0;
    dut_hs = 0; dut_sig = 0; dut_done = 0;

    // vector table: start/abort priority, buf_full gating, sig_en latency
    tv[0]  = '{0,0,0,0,0, 0,0,0};
    tv[1]  = '{1,1,0,0,0, 0,0,0};
    tv[2]  = '{0,0,0,0,0, 0,0,0};
    tv[3]  = '{1,0,0,0,0, 0,0,0};
    tv[4]  = '{0,0,1,0,0, 1,1,0};
    tv[5]  = '{0,0,1,1,0, 0,1,1};
    tv[6]  = '{0,1,1,0,0, 0,1,0};
    tv[7]  = '{1,0,0,0,0, 0,0,0};
    tv[8]  = '{1,0,0,0,0, 1,1,0};
    tv[9]  = '{0,1,0,0,0, 0,1,0};
    tv[10] = '{0,0,0,0,0, 0,0,0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    drive(0, 0, 0, 0, 0);
    eval();
    check("rst_busy", 32'(bus.o_busy), 0);
    check("rst_ready", 32'(bus.o_s_ready), 0);
    check("rst_sig_en", 32'(bus.o_sig_en), 0);
    check("rst_done", 32'(bus.o_done), 0);
    check("rst_err", 32'(bus.o_err), 0);
    tick();

    for (int i = 0; i < 11; i++) begin
      drive(tv[i].st, tv[i].ab, tv[i].sv, tv[i].bf, tv[i].ma);
      eval();
      check($sformatf("tv%0d_ready", i), 32'(bus.o_s_ready), 32'(tv[i].e_ready));
      check($sformatf("tv%0d_busy", i), 32'(bus.o_busy), 32'(tv[i].e_busy));
      check($sformatf("tv%0d_sig", i), 32'(bus.o_sig_en), 32'(tv[i].e_sig));
      tick();
    end

    // full run, mel every 3rd cycle
    dut_hs = 0; dut_sig = 0; dut_done = 0; fin = 0;
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 200 && !fin; k++) begin
      cyc(0, 0, 1, 0, (k % 3) == 2);
      if (dut_done > 0 && !bus.o_busy) fin = 1;
    end
    check("A_finished", 32'(fin), 1);
    check("A_hs", dut_hs, 16);
    check("A_sig", dut_sig, 16);
    check("A_done_cnt", dut_done, 1);

    // lead stall, release by a frame_done, then band sequence to done
    dut_hs = 0; fin = 0;
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 40 && !fin; k++) begin
      drive(0, 0, 1, 0, 0);
      eval();
      if (dut_hs > 0 && !bus.o_s_ready) fin = 1;
      tick();
    end
    check("B_stall_hs", dut_hs, 12);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 1); eval();
    check("B_band0", 32'(bus.o_band_idx), 0);
    check("B_fd0", 32'(bus.o_frame_done), 0);
    tick();
    drive(0, 0, 1, 0, 1); eval();
    check("B_band1", 32'(bus.o_band_idx), 1);
    check("B_fd1", 32'(bus.o_frame_done), 1);
    check("B_still_stalled", 32'(bus.o_s_ready), 0);
    tick();
    drive(0, 0, 1, 0, 0); eval();
    check("B_ready_back", 32'(bus.o_s_ready), 1);
    tick();
    for (int k = 0; k < 20 && dut_hs < 16; k++) cyc(0, 0, 1, 0, 0);
    check("B_hs16", dut_hs, 16);
    drive(0, 0, 1, 0, 0); eval();
    check("B_ready_drain", 32'(bus.o_s_ready), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1); eval();
      check($sformatf("B_band_%0d", i), 32'(bus.o_band_idx), 32'(i % 2));
      check($sformatf("B_fd_%0d", i), 32'(bus.o_frame_done), 32'(i % 2));
      check($sformatf("B_nodone_%0d", i), 32'(bus.o_done), 0);
      tick();
    end
    drive(0, 0, 0, 0, 0); eval();
    check("B_done", 32'(bus.o_done), 1);
    check("B_busy_in_done", 32'(bus.o_busy), 1);
    tick();
    drive(0, 0, 0, 0, 0); eval();
    check("B_busy_after", 32'(bus.o_busy), 0);
    check("B_done_after", 32'(bus.o_done), 0);
    tick();

    // buf_full for 5 cycles after hs #3
    dut_hs = 0;
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 20 && dut_hs < 3; k++) cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 1, 0); eval();
      check("C_bf_ready", 32'(bus.o_s_ready), 0);
      tick();
    end
    check("C_hs_hold", dut_hs, 3);
    drive(0, 0, 1, 0, 0); eval();
    check("C_resume", 32'(bus.o_s_ready), 1);
    tick();
    check("C_hs4", dut_hs, 4);
    cyc(0, 1, 0, 0, 0);

    // abort in HOP after hs #10, then a fresh full run
    dut_hs = 0;
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 30 && dut_hs < 10; k++) cyc(0, 0, 1, 0, 0);
    check("E_hs10", dut_hs, 10);
    drive(0, 1, 1, 0, 0); eval();
    check("E_abort_ready", 32'(bus.o_s_ready), 0);
    check("E_sig_inflight", 32'(bus.o_sig_en), 1);
    tick();
    drive(0, 0, 1, 0, 0); eval();
    check("E_idle", 32'(bus.o_busy), 0);
    check("E_ready0", 32'(bus.o_s_ready), 0);
    check("E_frame0", 32'(bus.o_frame_idx), 0);
    tick();
    dut_hs = 0; dut_done = 0; fin = 0;
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 200 && !fin; k++) begin
      cyc(0, 0, 1, 0, (k % 3) == 2);
      if (dut_done > 0 && !bus.o_busy) fin = 1;
    end
    check("E_rerun_fin", 32'(fin), 1);
    check("E_rerun_hs", dut_hs, 16);

    // DRAIN with no further mel strobes
    dut_hs = 0; dut_done = 0; mcount = 0;
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 60 && dut_hs < 16; k++) begin
      ma = ((k % 3) == 2) && (mcount < 4);
      if (ma) mcount++;
      cyc(0, 0, 1, 0, ma);
    end
    check("F_hs16", dut_hs, 16);
`ifdef MEL_CTRL_TIMEOUT_EN
    fin = 0;
    for (int k = 0; k < 40 && !fin; k++) begin
      cyc(0, 0, 0, 0, 0);
      if (!bus.o_busy) fin = 1;
    end
    check("F_timeout_idle", 32'(fin), 1);
    check("F_err", 32'(bus.o_err), 1);
    check("F_no_done", dut_done, 0);
`else
    repeat (40) cyc(0, 0, 0, 0, 0);
    check("F_waiting", 32'(bus.o_busy), 1);
    check("F_err0", 32'(bus.o_err), 0);
    check("F_no_done", dut_done, 0);
    cyc(0, 1, 0, 0, 0);
`endif

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom % 20) == 0, ($urandom % 200) == 0, ($urandom % 4) != 0,
          ($urandom % 8) == 0, ($urandom % 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
